// File: rtl/bsearch_pkg.sv
// Shared types and constants for the binary-search controller.
// Flag patterns are written in {GT,LT,EQ} order.
package bsearch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

endpackage

// File: rtl/bsearch_mid.sv
// Overflow-free midpoint lo + ((hi - lo) >> 1); the caller guarantees hi >= lo.
module bsearch_mid #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] hi_i,
    output logic [WIDTH-1:0] mid_o
);

    logic [WIDTH:0] diff;
    logic [WIDTH:0] sum;

    // One extra bit keeps the intermediate sum from wrapping at the top of the range.
    assign diff  = {1'b0, hi_i} - {1'b0, lo_i};
    assign sum   = {1'b0, lo_i} + (diff >> 1);
    assign mid_o = sum[WIDTH-1:0];

endmodule

// File: rtl/bin_search_ctrl.sv
// Successive-approximation search for a secret operand, driving GUESS into a
// registered GT/LT/EQ comparator and consuming its flags one cycle later.
module bin_search_ctrl
    import bsearch_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH + 2)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             GT,
    input  logic             LT,
    input  logic             EQ,
    output logic [WIDTH-1:0] GUESS,
    output logic             BUSY,
    output logic             DONE,
    output logic             FOUND,
    output logic [SW-1:0]    STEPS
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [SW-1:0]    STEP_ONE = SW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             found_q, found_d;

    logic [2:0]       flags;
    logic             step_gt, step_lt;
    logic [WIDTH-1:0] mid_lo, mid_hi, mid_val;

    assign flags = {GT, LT, EQ};

    // Bound checks come before the +/-1 update so GUESS never wraps at 0 or MAX_VAL.
    assign step_gt = (flags == F_GT) && (guess_q != lo_q);
    assign step_lt = (flags == F_LT) && (guess_q != hi_q);

    always_comb begin
        mid_lo = '0;
        mid_hi = MAX_VAL;
        if (state_q == CHECK) begin
            if (flags == F_GT) begin
                mid_lo = lo_q;
                mid_hi = guess_q - ONE;
            end else begin
                mid_lo = guess_q + ONE;
                mid_hi = hi_q;
            end
        end
    end

    bsearch_mid #(.WIDTH(WIDTH)) u_mid (
        .lo_i  (mid_lo),
        .hi_i  (mid_hi),
        .mid_o (mid_val)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: a default first means every path assigns state_d, so no latch.
        state_d = state_q;
        unique case (state_q)
            IDLE, FIN: if (START) state_d = WAIT;
            WAIT:      state_d = CHECK;
            CHECK: begin
                if (flags == F_EQ)        state_d = FIN;
                else if (step_gt || step_lt) state_d = WAIT;
                else                      state_d = FIN;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        guess_d = guess_q;
        steps_d = steps_q;
        found_d = found_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    lo_d    = '0;
                    hi_d    = MAX_VAL;
                    guess_d = mid_val;
                    steps_d = STEP_ONE;
                    found_d = 1'b0;
                end
            end
            CHECK: begin
                if (flags == F_EQ) begin
                    found_d = 1'b1;
                end else if (step_gt) begin
                    hi_d    = guess_q - ONE;
                    guess_d = mid_val;
                    steps_d = steps_q + STEP_ONE;
                end else if (step_lt) begin
                    lo_d    = guess_q + ONE;
                    guess_d = mid_val;
                    steps_d = steps_q + STEP_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lo_q    <= '0;
            hi_q    <= MAX_VAL;
            guess_q <= '0;
            steps_q <= '0;
            found_q <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            guess_q <= guess_d;
            steps_q <= steps_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        GUESS = guess_q;
        STEPS = steps_q;
        FOUND = found_q;
        BUSY  = (state_q == WAIT) || (state_q == CHECK);
        DONE  = (state_q == FIN);
    end

endmodule

// File: doc/bin_search_ctrl.md
Name: bin_search_ctrl

Overview:
- Initiator side of the magnitude-compare interface: drives the A operand (GUESS) into a registered GT/LT/EQ comparator and consumes its flags.
- Finds an unknown B operand (secret value) by successive-approximation binary search.
- Sits between a START button and the comparator. GUESS, FOUND and DONE drive LEDs/7-seg.

Parameters:
WIDTH, 4, operand width in bits; search range 0 .. 2^WIDTH-1
SW, $clog2(WIDTH+2), width of STEPS counter (max steps = WIDTH+1)

Ports:
CLK    input   1      system clock, rising edge
RST    input   1      asynchronous, active-low reset (0 = reset)
START  input   1      begin search (level sampled each cycle; caller supplies a 1-cycle pulse or debounced level)
GT     input   1      comparator flag: GUESS > secret
LT     input   1      comparator flag: GUESS < secret
EQ     input   1      comparator flag: GUESS == secret
GUESS  output  WIDTH  operand driven to comparator A input
BUSY   output  1      search in progress
DONE   output  1      search finished; level, held until next START
FOUND  output  1      valid with DONE: 1 = EQ reached, 0 = search failed
STEPS  output  SW     number of guesses issued in current/last search

Behaviour:
- Reset (RST=0, async): state IDLE. GUESS=0, BUSY=0, DONE=0, FOUND=0, STEPS=0, lo=0, hi=2^WIDTH-1.
- Comparator contract: flags are registered with 1-cycle latency after GUESS changes. Each step therefore takes 2 cycles: WAIT, then CHECK.
- States: IDLE, WAIT, CHECK, FIN.
- IDLE/FIN with START=1:
  - lo=0, hi=2^WIDTH-1, GUESS=(2^WIDTH-1)>>1, STEPS=1.
  - BUSY=1, DONE=0, FOUND=0; go to WAIT.
- WAIT: hold everything; go to CHECK next cycle.
- CHECK: sample {GT,LT,EQ}.
  - 001 (EQ): FOUND=1, DONE=1, BUSY=0 -> FIN; GUESS holds the found value.
  - 100 (GT): if GUESS==lo, fail. Else hi=GUESS-1, GUESS=lo+((GUESS-1-lo)>>1), STEPS+1 -> WAIT.
  - 010 (LT): if GUESS==hi, fail. Else lo=GUESS+1, GUESS=(GUESS+1)+((hi-GUESS-1)>>1), STEPS+1 -> WAIT.
  - Any other pattern (000, multiple bits set): fail.
  - Fail: DONE=1, FOUND=0, BUSY=0 -> FIN; GUESS holds the last value.
- Arithmetic:
  - Midpoint computed in WIDTH+1 bits, so lo+hi never overflows.
  - The GUESS==lo / GUESS==hi checks precede the ±1 update, so there is no wrap at 0 or 2^WIDTH-1.
- START while BUSY: ignored.
- START in FIN: restarts search; DONE drops the next cycle.
- FIN without START: all outputs held indefinitely.
- Reset mid-search: immediate return to reset values; no partial state survives.
- STEPS never exceeds WIDTH+1 for a consistent comparator.

Decomposition:
- Shared package bsearch_pkg:
  - state enum (IDLE, WAIT, CHECK, FIN)
  - flag pattern constants F_GT=3'b100, F_LT=3'b010, F_EQ=3'b001, in {GT,LT,EQ} order
- One natural sub-module: bsearch_mid (combinational, WIDTH-parameterised, returns lo+((hi-lo)>>1)). Reused for the initial guess and both update branches.
- Bench instantiates the existing comparator as the responder, with B tied to the secret.

Test Plan:
- WIDTH=4, secret=11, START pulse -> GUESS sequence 7, 11; DONE=1, FOUND=1, GUESS=11, STEPS=2, total 4 cycles from START to DONE.
- Secret=0 -> GUESS 7, 3, 1, 0; FOUND=1, STEPS=4; no underflow.
- Secret=15 -> GUESS 7, 11, 13, 14, 15; FOUND=1, STEPS=5 (= WIDTH+1); no overflow.
- Comparator held in reset (flags 000) -> first CHECK fails: DONE=1, FOUND=0, STEPS=1, GUESS=7. Forcing GT with GUESS=0 -> fail, no wrap to 15.
- START re-pulsed during BUSY (secret=5) -> ignored: sequence 7, 3, 5, STEPS=3. START in FIN with new secret=9 -> DONE falls next cycle; new search finds 9.
- RST=0 asserted mid-search (during WAIT) -> same-edge async clear: GUESS=0, BUSY=0, DONE=0, STEPS=0. After release, START finds the secret normally.
